// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control unit: state and display-mode
// encodings, plus the default width of the clear pulse.
package stopwatch_pkg;

  // Control-unit states; the numeric values are also shown on the debug LEDs.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  // Display-mode encodings driven on o_mode.
  localparam logic MODE_SEC = 1'b0;  // sec.centisec
  localparam logic MODE_HM  = 1'b1;  // hour.min

  // Default length, in clk cycles, of the datapath clear pulse.
  localparam int unsigned CLR_CYCLES_DEF = 4;

endpackage : stopwatch_pkg

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit. Turns one-cycle button ticks into the registered
// run-enable, clear, lap-hold and display-mode controls for the datapath.
// Every output is a flop, so each output reacts one clk after its tick.
module stopwatch_cu
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int unsigned STATE_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_btn_run,
  input  logic               i_btn_clear,
  input  logic               i_btn_lap,
  input  logic               i_btn_mode,
  output logic               o_run_en,
  output logic               o_clear,
  output logic               o_lap_hold,
  output logic               o_mode,
  output logic [STATE_W-1:0] o_state
);

  // Counter just wide enough for 0..CLR_CYCLES-1 (at least one bit).
  localparam int unsigned CntW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLR_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            run_en_q;
  logic            clear_q;
  logic            lap_hold_q;
  logic            mode_q;

  // Display mode toggles on every mode tick regardless of the FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_SEC;
    end else if (i_btn_mode) begin
      mode_q <= ~mode_q;
    end
  end

  // Main FSM with registered outputs; clear > run > lap when ticks coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      run_en_q   <= 1'b0;
      clear_q    <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_btn_clear) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            clear_q    <= 1'b1;
            run_en_q   <= 1'b0;
            lap_hold_q <= 1'b0;
          end else if (i_btn_run) begin
            state_q  <= ST_RUN;
            run_en_q <= 1'b1;
          end
        end

        ST_RUN: begin
          // Clear is illegal while running; lap still acts alongside run.
          if (i_btn_run) begin
            state_q  <= ST_STOP;
            run_en_q <= 1'b0;
          end
          if (i_btn_lap) begin
            lap_hold_q <= ~lap_hold_q;
          end
        end

        ST_STOP: begin
          if (i_btn_clear) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            clear_q    <= 1'b1;
            run_en_q   <= 1'b0;
            lap_hold_q <= 1'b0;
          end else if (i_btn_run) begin
            // Resuming keeps whatever lap freeze was in place.
            state_q  <= ST_RUN;
            run_en_q <= 1'b1;
          end else if (i_btn_lap && lap_hold_q) begin
            // A stopped watch can release a lap freeze but not start one.
            lap_hold_q <= 1'b0;
          end
        end

        ST_CLEAR: begin
          // Hold clear for CLR_CYCLES cycles, ignoring run/clear/lap ticks.
          if (cnt_q == CntLast) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            clear_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          run_en_q   <= 1'b0;
          clear_q    <= 1'b0;
          lap_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_run_en   = run_en_q;
  assign o_clear    = clear_q;
  assign o_lap_hold = lap_hold_q;
  assign o_mode     = mode_q;
  assign o_state    = STATE_W'(state_q);

endmodule : stopwatch_cu

// File: tb/tb_stopwatch_cu.sv
// Self-checking bench for stopwatch_cu: a directed vector table, an async
// reset in the middle of a clear pulse, then random ticks against a model.
module tb_stopwatch_cu;

  localparam int unsigned CLR     = 4;
  localparam int unsigned STATE_W = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               btn_run = 1'b0;
  logic               btn_clear = 1'b0;
  logic               btn_lap = 1'b0;
  logic               btn_mode = 1'b0;
  logic               run_en;
  logic               clear;
  logic               lap_hold;
  logic               mode;
  logic [STATE_W-1:0] state;

  int errors = 0;
  int checks = 0;

  // Reference model: abstract phase number plus clear cycles still to go.
  int m_phase;
  int m_hold;
  int m_mode;
  int m_left;

  stopwatch_cu #(
    .CLR_CYCLES(CLR),
    .STATE_W   (STATE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn_run  (btn_run),
    .i_btn_clear(btn_clear),
    .i_btn_lap  (btn_lap),
    .i_btn_mode (btn_mode),
    .o_run_en   (run_en),
    .o_clear    (clear),
    .o_lap_hold (lap_hold),
    .o_mode     (mode),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, c, l, m;
    int   st, run_e, clr, hold, md;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic l, logic m,
                              int st, int re, int cl, int h, int md);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.m = m;
    v.st = st; v.run_e = re; v.clr = cl; v.hold = h; v.md = md;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int re, input int cl,
                         input int h, input int md);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".run_en"}, int'(run_en), re);
    chk({tag, ".clear"}, int'(clear), cl);
    chk({tag, ".lap_hold"}, int'(lap_hold), h);
    chk({tag, ".mode"}, int'(mode), md);
  endtask

  task automatic model_reset();
    m_phase = 0; m_hold = 0; m_mode = 0; m_left = 0;
  endtask

  // Behavioural rules: clear beats run beats lap; mode is independent.
  task automatic model_step(input logic r, input logic c, input logic l, input logic m);
    if (m) m_mode = 1 - m_mode;
    case (m_phase)
      0: begin
        if (c) begin m_phase = 3; m_hold = 0; m_left = CLR; end
        else if (r) m_phase = 1;
      end
      1: begin
        if (l) m_hold = 1 - m_hold;
        if (r) m_phase = 2;
      end
      2: begin
        if (c) begin m_phase = 3; m_hold = 0; m_left = CLR; end
        else if (r) m_phase = 1;
        else if (l) m_hold = 0;
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
  endtask

  task automatic model_check(input string tag);
    chk_all(tag, m_phase, (m_phase == 1) ? 1 : 0, (m_phase == 3) ? 1 : 0, m_hold, m_mode);
  endtask

  // Apply ticks across one rising edge; leaves time at edge+1 with ticks low.
  task automatic cycle(input logic r, input logic c, input logic l, input logic m);
    btn_run = r; btn_clear = c; btn_lap = l; btn_mode = m;
    @(posedge clk);
    #1;
    btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0; btn_mode = 1'b0;
  endtask

  initial begin
    // Directed sequence: inputs r,c,l,m then expected state,run_en,clear,hold,mode.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));  // lap ignored in IDLE
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));  // start
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 0));  // lap freeze
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0));  // lap release
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));  // clear ignored in RUN
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 2, 0, 0, 0, 0));  // run+clear+lap in RUN
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 0, 0, 0));  // lap with hold=0 in STOP
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1, 0));  // stop keeps hold
    vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 1, 0));  // run beats lap in STOP
    vecs.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 0, 0, 0));  // lap releases in STOP
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 3, 0, 1, 0, 1));  // clear wins, hold forced 0
    vecs.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 1));  // run ignored in CLEAR
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 1, 0, 0));  // mode honoured in CLEAR
    vecs.push_back(mk(0, 1, 1, 0, 3, 0, 1, 0, 0));  // 4th clear cycle
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));  // back to IDLE
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 3, 0, 1, 0, 1));  // clear beats run in IDLE
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 2, 0, 0, 0, 0));  // run+clear in RUN -> STOP

    // Reset values, checked while reset is still asserted and after release.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("reset_rel", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].m);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].run_e, vecs[i].clr,
              vecs[i].hold, vecs[i].md);
    end

    // Async reset at cycle 2 of a clear pulse, between clock edges.
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    chk_all("clr_c1", 3, 0, 1, 0, 1);
    cycle(0, 0, 0, 0);
    chk_all("clr_c2", 3, 0, 1, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cycle(0, 0, 0, 0);
    chk_all("post_rst", 0, 0, 0, 0, 0);

    // Held-high malformed tick: acted on once per cycle.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk_all("held_run2", 2, 0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk_all("held_run3", 1, 1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    model_step(1, 0, 0, 0);

    // Random ticks against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic r, c, l, m;
      r = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 4) == 0);
      l = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 5) == 0);
      cycle(r, c, l, m);
      model_step(r, c, l, m);
      model_check($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stopwatch_cu

// File: doc/stopwatch_cu.md
Name: stopwatch_cu

Overview:
Control unit for the stopwatch. Consumes one-cycle button ticks, which come from the per-button debouncers after their rising-edge detectors. Sequences the stopwatch counter datapath through idle, run, stop and clear phases, and also manages lap-freeze and display-mode selection. Sits between the debouncers and the stopwatch datapath/FND display in the top level.

Parameters:
CLR_CYCLES, 4, width in clk cycles of the o_clear pulse issued on a clear command (>=1).
STATE_W, 2, width of the o_state debug output.

Ports:
clk  input  1  system clock (100 MHz).
rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
i_btn_run  input  1  run/stop toggle tick, one clk wide.
i_btn_clear  input  1  clear tick, one clk wide.
i_btn_lap  input  1  lap freeze/release tick, one clk wide.
i_btn_mode  input  1  display-mode toggle tick, one clk wide.
o_run_en  output  1  datapath count enable.
o_clear  output  1  datapath synchronous clear.
o_lap_hold  output  1  display latch freeze (datapath keeps counting).
o_mode  output  1  display select: 0 = sec.centisec, 1 = hour.min.
o_state  output  STATE_W  current FSM state, for debug LEDs.

Behaviour:
- Reset (rst=0, async) gives: state IDLE; all outputs 0; clear counter 0. Reset mid-CLEAR aborts the pulse immediately.
- States: IDLE=0, RUN=1, STOP=2, CLEAR=3. All outputs are registered (Moore). Each output changes on the clk edge after the tick is sampled, so latency is 1 cycle.
- IDLE:
  - run tick -> RUN.
  - clear tick -> CLEAR.
  - lap tick ignored.
- RUN:
  - o_run_en=1.
  - run tick -> STOP.
  - clear tick ignored; a running watch cannot be cleared.
  - lap tick toggles o_lap_hold.
- STOP:
  - o_run_en=0.
  - run tick -> RUN; o_lap_hold keeps its value.
  - clear tick -> CLEAR.
  - lap tick with o_lap_hold=1 -> o_lap_hold=0; with o_lap_hold=0 it is ignored.
- CLEAR:
  - o_clear=1 and o_run_en=0 for exactly CLR_CYCLES cycles. The counter counts 0..CLR_CYCLES-1, then the FSM goes to IDLE.
  - o_lap_hold is forced to 0 on entry.
  - All ticks except mode are ignored while in CLEAR.
- Mode: a mode tick toggles o_mode in every state, including CLEAR. o_mode is independent of the FSM.
- Simultaneous ticks in the same cycle, priority clear > run > lap:
  - clear wins where it is legal (IDLE, STOP).
  - In RUN, clear is illegal, so run+clear -> STOP.
  - run+lap in RUN -> STOP, and lap still toggles o_lap_hold.
  - A mode tick is always honoured in parallel with any other tick.
- A tick held high for more than one cycle (malformed input) is acted on once per cycle. There is no internal edge detection; this is the debouncer's contract.
- o_state = state encoding, zero-extended to STATE_W.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state localparams ST_IDLE, ST_RUN, ST_STOP, ST_CLEAR;
  - the mode encodings MODE_SEC, MODE_HM;
  - the default CLR_CYCLES.
- No sub-module is needed; the CLEAR pulse counter is inline.
- The top level instantiates four btn_debounce blocks feeding this unit.

Test Plan:
1. Release reset, then run tick at t0 -> o_run_en=1 at t0+1 cycle, o_state=1. Second run tick -> o_run_en=0, o_state=2.
2. From STOP, clear tick -> o_clear=1 for exactly 4 cycles (default), o_state=3. Then o_state=0 and o_clear=0 on cycle 5.
3. In RUN, lap tick -> o_lap_hold=1 with o_run_en still 1; second lap tick -> o_lap_hold=0. Clear tick in RUN -> no change.
4. In RUN with o_lap_hold=1, assert run+clear+lap in one cycle -> state STOP, o_lap_hold=0, o_clear stays 0.
5. Mode tick in IDLE, RUN and CLEAR -> o_mode toggles 0->1->0->1, with no effect on o_state.
6. Pull rst low asynchronously at cycle 2 of CLEAR (mid-cycle, no clk edge) -> all outputs 0 immediately. After release, o_state=0.
